// File: rtl/mem_arbiter_pkg.sv
// Shared constants, client ids and FSM state type for the memory arbiter.
package mem_arbiter_pkg;

    localparam int MEM_ADDR_BITS = 28;
    localparam int MEM_DATA_BITS = 128;
    localparam int MEM_MASK_BITS = MEM_DATA_BITS / 8;

    localparam logic ARB_ID_IC = 1'b0;
    localparam logic ARB_ID_DC = 1'b1;

    typedef enum logic {
        ARB   = 1'b0,
        WLOCK = 1'b1
    } arbState_e;

    // Picks the client to serve: a lone requester wins, a tie goes to the
    // client that was not served last.
    function automatic logic pickWinner(input logic icValid,
                                        input logic dcValid,
                                        input logic rrLast);
        logic winner;
        if (icValid && dcValid) begin
            winner = ~rrLast;
        end else if (dcValid) begin
            winner = ARB_ID_DC;
        end else begin
            winner = ARB_ID_IC;
        end
        return winner;
    endfunction

endpackage

// File: rtl/mem_arb_owner_fifo.sv
// One-bit-wide FIFO remembering which client issued each outstanding read,
// so in-order memory responses can be steered back to their owner.
module mem_arb_owner_fifo
    import mem_arbiter_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic pushId,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PTR_BITS = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_BITS + 1;

    logic [DEPTH-1:0]    slots_q;
    logic [PTR_BITS-1:0] wrPtr_q, wrPtr_d;
    logic [PTR_BITS-1:0] rdPtr_q, rdPtr_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                doPush;
    logic                doPop;

    assign full   = (count_q == CNT_BITS'(DEPTH));
    assign empty  = (count_q == '0);
    assign head   = slots_q[rdPtr_q];
    assign doPop  = pop && !empty;
    assign doPush = push && (!full || doPop);

    // Next pointer and occupancy values; a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (doPush) begin
            wrPtr_d = wrPtr_q + 1'b1;
        end
        if (doPop) begin
            rdPtr_d = rdPtr_q + 1'b1;
        end
        if (doPush && !doPop) begin
            count_d = count_q + 1'b1;
        end else if (doPop && !doPush) begin
            count_d = count_q - 1'b1;
        end
    end

    // Storage and pointer registers, cleared by the synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            slots_q <= '0;
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (doPush) begin
                slots_q[wrPtr_q] <= pushId;
            end
            wrPtr_q <= wrPtr_d;
            rdPtr_q <= rdPtr_d;
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Merges the icache and dcache main-memory ports onto one memory port:
// round-robin arbitration, write grant lock across a beat, and owner-tracked
// steering of in-order read responses.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_BITS = MEM_ADDR_BITS,
    parameter int DATA_BITS = MEM_DATA_BITS,
    parameter int MAX_OUTST = 4
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   ic_mem_req_valid,
    output logic                   ic_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   ic_mem_req_addr,
    input  logic                   ic_mem_req_rw,
    input  logic                   ic_mem_req_data_valid,
    output logic                   ic_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   ic_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] ic_mem_req_data_mask,
    output logic                   ic_mem_resp_valid,
    output logic [DATA_BITS-1:0]   ic_mem_resp_data,

    input  logic                   dc_mem_req_valid,
    output logic                   dc_mem_req_ready,
    input  logic [ADDR_BITS-1:0]   dc_mem_req_addr,
    input  logic                   dc_mem_req_rw,
    input  logic                   dc_mem_req_data_valid,
    output logic                   dc_mem_req_data_ready,
    input  logic [DATA_BITS-1:0]   dc_mem_req_data_bits,
    input  logic [DATA_BITS/8-1:0] dc_mem_req_data_mask,
    output logic                   dc_mem_resp_valid,
    output logic [DATA_BITS-1:0]   dc_mem_resp_data,

    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_BITS-1:0]   mem_req_addr,
    output logic                   mem_req_rw,
    output logic                   mem_req_data_valid,
    input  logic                   mem_req_data_ready,
    output logic [DATA_BITS-1:0]   mem_req_data_bits,
    output logic [DATA_BITS/8-1:0] mem_req_data_mask,
    input  logic                   mem_resp_valid,
    input  logic [DATA_BITS-1:0]   mem_resp_data,

    output logic                   arb_err
);

    arbState_e state_q;
    logic      rrLast_q;
    logic      lockId_q;
    logic      reqDone_q;
    logic      dataDone_q;
    logic      err_q;

    logic                   grantId;
    logic                   grantActive;
    logic                   selValid;
    logic [ADDR_BITS-1:0]   selAddr;
    logic                   selRw;
    logic                   selDataValid;
    logic [DATA_BITS-1:0]   selBits;
    logic [DATA_BITS/8-1:0] selMask;
    logic                   reqHs;
    logic                   dataHs;
    logic                   fifoFull;
    logic                   fifoEmpty;
    logic                   fifoHead;
    logic                   fifoPush;
    logic                   fifoPop;
    logic                   fifoBlocked;

    // Chooses the granted client: the locked writer in WLOCK, otherwise the round-robin winner.
    always_comb begin
        grantId     = lockId_q;
        grantActive = 1'b1;
        if (state_q == ARB) begin
            grantId     = pickWinner(ic_mem_req_valid, dc_mem_req_valid, rrLast_q);
            grantActive = ic_mem_req_valid || dc_mem_req_valid;
        end
    end

    // Selects the granted client's request and write-data fields.
    always_comb begin
        if (grantId == ARB_ID_DC) begin
            selValid     = dc_mem_req_valid;
            selAddr      = dc_mem_req_addr;
            selRw        = dc_mem_req_rw;
            selDataValid = dc_mem_req_data_valid;
            selBits      = dc_mem_req_data_bits;
            selMask      = dc_mem_req_data_mask;
        end else begin
            selValid     = ic_mem_req_valid;
            selAddr      = ic_mem_req_addr;
            selRw        = ic_mem_req_rw;
            selDataValid = ic_mem_req_data_valid;
            selBits      = ic_mem_req_data_bits;
            selMask      = ic_mem_req_data_mask;
        end
    end

    assign fifoPop     = reset && mem_resp_valid && !fifoEmpty;
    assign fifoBlocked = fifoFull && !fifoPop;

    // Drives the memory request channels from the granted client; a write in WLOCK only forwards the unfinished channel.
    always_comb begin
        mem_req_valid      = 1'b0;
        mem_req_data_valid = 1'b0;
        mem_req_addr       = '0;
        mem_req_rw         = 1'b0;
        mem_req_data_bits  = '0;
        mem_req_data_mask  = '0;
        if (reset && grantActive) begin
            mem_req_addr      = selAddr;
            mem_req_rw        = selRw;
            mem_req_data_bits = selBits;
            mem_req_data_mask = selMask;
            if (state_q == WLOCK) begin
                mem_req_valid      = selValid && !reqDone_q;
                mem_req_data_valid = selDataValid && !dataDone_q;
            end else begin
                mem_req_valid      = selValid && (selRw || !fifoBlocked);
                mem_req_data_valid = selValid && selRw && selDataValid;
            end
        end
    end

    assign reqHs  = mem_req_valid && mem_req_ready;
    assign dataHs = mem_req_data_valid && mem_req_data_ready;

    assign ic_mem_req_ready      = reqHs && (grantId == ARB_ID_IC);
    assign dc_mem_req_ready      = reqHs && (grantId == ARB_ID_DC);
    assign ic_mem_req_data_ready = dataHs && (grantId == ARB_ID_IC);
    assign dc_mem_req_data_ready = dataHs && (grantId == ARB_ID_DC);

    assign fifoPush = reqHs && !selRw && (state_q == ARB);

    assign ic_mem_resp_valid = fifoPop && (fifoHead == ARB_ID_IC);
    assign dc_mem_resp_valid = fifoPop && (fifoHead == ARB_ID_DC);
    assign ic_mem_resp_data  = mem_resp_data;
    assign dc_mem_resp_data  = mem_resp_data;

    assign arb_err = err_q && reset;

    mem_arb_owner_fifo #(
        .DEPTH (MAX_OUTST)
    ) ownerFifo (
        .clk    (clk),
        .reset  (reset),
        .push   (fifoPush),
        .pushId (grantId),
        .pop    (fifoPop),
        .full   (fifoFull),
        .empty  (fifoEmpty),
        .head   (fifoHead)
    );

    // Arbitration FSM: completes reads and same-cycle writes in ARB, locks the writer until both channels finish.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= ARB;
            rrLast_q   <= ARB_ID_IC;
            lockId_q   <= ARB_ID_IC;
            reqDone_q  <= 1'b0;
            dataDone_q <= 1'b0;
        end else begin
            case (state_q)
                ARB: begin
                    if (grantActive && selValid) begin
                        if (selRw) begin
                            if (reqHs && dataHs) begin
                                rrLast_q <= grantId;
                            end else begin
                                state_q    <= WLOCK;
                                lockId_q   <= grantId;
                                reqDone_q  <= reqHs;
                                dataDone_q <= dataHs;
                            end
                        end else if (reqHs) begin
                            rrLast_q <= grantId;
                        end
                    end
                end
                WLOCK: begin
                    if ((reqDone_q || reqHs) && (dataDone_q || dataHs)) begin
                        state_q    <= ARB;
                        rrLast_q   <= lockId_q;
                        reqDone_q  <= 1'b0;
                        dataDone_q <= 1'b0;
                    end else begin
                        if (reqHs) begin
                            reqDone_q <= 1'b1;
                        end
                        if (dataHs) begin
                            dataDone_q <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= ARB;
                end
            endcase
        end
    end

    // Sticky error flag for a memory response that arrives with no read outstanding.
    always_ff @(posedge clk) begin
        if (!reset) begin
            err_q <= 1'b0;
        end else if (mem_resp_valid && fifoEmpty) begin
            err_q <= 1'b1;
        end
    end

endmodule
